// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand buffers and sequencer that stream one neuron's (W,X) pairs into rmac
module mac_operand_feeder #(
    parameter int S  = 8,
    parameter int n  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [n-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mac_rst,
    output logic [n-1:0]  W_out,
    output logic [n-1:0]  X_out
);

    // Step counter sized for S+2 so it can never wrap, even with S = 2^AW.
    localparam int CW = AW + 2;
    // Index width into the S-entry arrays (at least one bit for S = 1).
    localparam int IW = (S > 1) ? $clog2(S) : 1;

    localparam logic [CW-1:0] STREAM_LAST = CW'(S - 1);
    localparam logic [CW-1:0] PRIME_LAST  = CW'(1);
    localparam logic [AW:0]   S_LIMIT     = (AW + 1)'(S);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RST    = 3'd1;
    localparam logic [2:0] PRIME  = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] step;
    logic [n-1:0]  wbuf [0:S-1];
    logic [n-1:0]  xbuf [0:S-1];
    logic          write_ok;
    logic          in_stream;

    // Buffers are writable only between evaluations, and only for in-range indices.
    assign write_ok = wr_en && ((state == IDLE) || (state == DONE))
                      && ({1'b0, wr_addr} < S_LIMIT);

    // Operand buffers: cleared by reset, otherwise loaded one word per accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < S; i++) begin
                wbuf[i] <= '0;
                xbuf[i] <= '0;
            end
        end else if (write_ok) begin
            if (wr_sel) begin
                xbuf[wr_addr[IW-1:0]] <= wr_data;
            end else begin
                wbuf[wr_addr[IW-1:0]] <= wr_data;
            end
        end
    end

    // Sequencer: RST (1) -> PRIME (2) -> STREAM (S) -> SETTLE (1) -> DONE (1).
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    step <= '0;
                    if (start) begin
                        state <= RST;
                    end
                end
                RST: begin
                    state <= PRIME;
                    step  <= '0;
                end
                PRIME: begin
                    if (step == PRIME_LAST) begin
                        state <= STREAM;
                        step  <= '0;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                STREAM: begin
                    if (step == STREAM_LAST) begin
                        state <= SETTLE;
                        step  <= '0;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                SETTLE: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= start ? RST : IDLE;
                end
                default: begin
                    state <= IDLE;
                    step  <= '0;
                end
            endcase
        end
    end

    // Outputs decode from registered state; reset forces the idle view immediately.
    assign in_stream = (state == STREAM) && !reset;
    assign W_out     = in_stream ? wbuf[step[IW-1:0]] : '0;
    assign X_out     = in_stream ? xbuf[step[IW-1:0]] : '0;
    assign busy      = !reset && (state != IDLE);
    assign done      = !reset && (state == DONE);
    assign mac_rst   = reset || (state == RST);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - randomized and directed self-checking bench for mac_operand_feeder
module tb_mac_operand_feeder;

    localparam int S  = 8;
    localparam int N  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, mac_rst;
    logic [N-1:0]  W_out, X_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mac_operand_feeder #(.S(S), .n(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .mac_rst(mac_rst),
        .W_out(W_out), .X_out(X_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: an evaluation is a timeline t = 0..S+4 measured from the RST cycle
    // (0 = rmac reset, 1..2 prime, 3..S+2 operand k = t-3, S+3 settle, S+4 done).
    int          m_t = -1;
    bit          m_ok = 0;
    logic [N-1:0] m_w [S];
    logic [N-1:0] m_x [S];

    always @(posedge clk) begin
        if (reset) begin
            m_t  <= -1;
            m_ok <= 1'b1;
            for (int i = 0; i < S; i++) begin
                m_w[i] <= '0;
                m_x[i] <= '0;
            end
        end else begin
            if (wr_en && (m_t == -1 || m_t == S + 4) && int'(wr_addr) < S) begin
                if (wr_sel) m_x[int'(wr_addr)] <= wr_data;
                else        m_w[int'(wr_addr)] <= wr_data;
            end
            if (m_t == -1 || m_t == S + 4) m_t <= start ? 0 : -1;
            else                           m_t <= m_t + 1;
        end
    end

    // Every cycle once reset has been seen, all outputs must match the timeline.
    always @(negedge clk) begin
        if (m_ok) begin
            logic          streaming;
            logic [N-1:0]  ew, ex;
            streaming = !reset && m_t >= 3 && m_t < 3 + S;
            ew = streaming ? m_w[m_t - 3] : '0;
            ex = streaming ? m_x[m_t - 3] : '0;
            chk("busy",    busy,    !reset && m_t >= 0);
            chk("done",    done,    !reset && m_t == S + 4);
            chk("mac_rst", mac_rst, reset || m_t == 0);
            chk("W_out",   W_out,   ew);
            chk("X_out",   X_out,   ex);
        end
    end

    // Sign-magnitude Q12.20 to a plain signed integer in 2^-20 units.
    function automatic longint sm2q(input logic [31:0] v);
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction

    int done_q[$];
    int rst_q[$];

    task automatic wr(input bit sel, input int a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_addr = a[AW-1:0]; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // mode 0 plain, 1 busy writes + stray starts, 2 reset mid-stream, 3 start held, 4 write with start.
    task automatic run(input int mode, output int first_done, output logic [31:0] sum);
        longint acc;
        int     maxrel;
        acc = 0;
        first_done = -1;
        done_q.delete();
        rst_q.delete();
        maxrel = (mode == 3) ? 46 : 30;
        @(posedge clk); #1;
        start = 1'b1;
        if (mode == 4) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 32'h0020_0000;
        end
        for (int rel = 0; rel < maxrel; rel++) begin
            if (rel > 0) begin
                @(posedge clk); #1;
                start   = (mode == 3) || (mode == 1 && (rel == 5 || rel == 6 || rel == 9));
                wr_en   = (mode == 1) && (rel == 3 || rel == 4);
                wr_sel  = 1'b0;
                wr_addr = (rel == 3) ? 4'd3 : 4'd9;
                wr_data = (rel == 3) ? 32'h0030_0000 : 32'h0050_0000;
                reset   = (mode == 2) && (rel == 8);
            end
            @(negedge clk);
            if (mac_rst) rst_q.push_back(rel);
            if (done) done_q.push_back(rel);
            if (first_done < 0) acc += (sm2q(W_out) * sm2q(X_out)) >>> 20;
            if (done && first_done < 0) first_done = rel;
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; reset = 1'b0;
        repeat (16) @(posedge clk);
        sum = (acc < 0) ? 32'h0 : {1'b0, acc[30:0]};
    endtask

    int          lat;
    logic [31:0] sum;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_done",    done,    1'b0);
        chk("rst_mac_rst", mac_rst, 1'b1);
        chk("rst_W_out",   W_out,   32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1.0 * 1.0 over eight pairs
        for (int k = 0; k < S; k++) begin
            wr(0, k, 32'h0010_0000);
            wr(1, k, 32'h0010_0000);
        end
        run(0, lat, sum);
        chk("t1_latency", lat, 13);
        chk("t1_sum", sum, 32'h0080_0000);
        chk("t1_rst_n", rst_q.size(), 1);
        chk("t1_rst_c1", rst_q.size() > 0 ? rst_q[0] : -1, 1);

        // alternating +2.0 / -2.0 activations
        for (int k = 0; k < S; k++) wr(1, k, (k % 2) ? 32'h8020_0000 : 32'h0020_0000);
        run(0, lat, sum);
        chk("t2_latency", lat, 13);
        chk("t2_sum", sum, 32'h0);

        // all -1.0: negative psum clipped by ReLU
        for (int k = 0; k < S; k++) wr(1, k, 32'h8010_0000);
        run(0, lat, sum);
        chk("t3_sum", sum, 32'h0);
        chk("t3_rst_n", rst_q.size(), 1);
        chk("t3_rst_c1", rst_q.size() > 0 ? rst_q[0] : -1, 1);

        // frozen buffers: busy writes and out-of-range write ignored, stray starts dropped
        for (int k = 0; k < S; k++) wr(1, k, 32'h0010_0000);
        wr(0, 9, 32'h0070_0000);
        run(1, lat, sum);
        chk("t4_latency", lat, 13);
        chk("t4_sum", sum, 32'h0080_0000);
        chk("t4_done_n", done_q.size(), 1);

        // reset during STREAM k=4 aborts with no done
        run(2, lat, sum);
        chk("t5_done_n", done_q.size(), 0);
        chk("t5_rst_n", rst_q.size(), 2);
        chk("t5_rst_reset", rst_q.size() > 1 ? rst_q[1] : -1, 8);
        for (int k = 0; k < S; k++) begin
            wr(0, k, 32'h0010_0000);
            wr(1, k, k << 19);
        end
        run(0, lat, sum);
        chk("t5_sum", sum, 32'h00E0_0000);

        // write coinciding with start is streamed
        for (int k = 0; k < S; k++) wr(1, k, 32'h0010_0000);
        run(4, lat, sum);
        chk("t6_sum", sum, 32'h0090_0000);

        // start held: period of S+5
        run(3, lat, sum);
        chk("t7_done_n", done_q.size(), 3);
        chk("t7_rst_n", rst_q.size(), 4);
        for (int i = 0; i < 3; i++)
            chk("t7_done_at", done_q.size() > i ? done_q[i] : -1, 13 * (i + 1));
        for (int i = 0; i < 4; i++)
            chk("t7_rst_at", rst_q.size() > i ? rst_q[i] : -1, 1 + 13 * i);

        // random traffic, checked every cycle against the timeline
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset   = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 9) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_sel  = $urandom_range(0, 1);
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; reset = 1'b0;
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
